// File: rtl/dot_product_pipe_pkg.sv
// Shared constants and width helpers for the dot-product pipeline.
// DOT_ACCUM_EN selects the frame-accumulator build.
package dot_pkg;

    localparam int W_DEF            = 16;
    localparam int N_DEF            = 4;
    localparam int ACC_FRAMES_W_DEF = 8;

`ifdef DOT_ACCUM_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    function automatic int log2n(input int n);
        return $clog2(n);
    endfunction

    // Width of adder-tree level k: products are 2W, each level adds one carry bit.
    function automatic int lvl_w(input int w, input int k);
        return (w * 32'sd2) + k;
    endfunction

    function automatic int out_w(input int w, input int n, input int acc_w);
        return lvl_w(w, log2n(n)) + acc_w;
    endfunction

    function automatic int lat_of(input int n, input bit acc);
        return 32'sd1 + log2n(n) + (acc ? 32'sd1 : 32'sd0);
    endfunction

    localparam int OUT_W_DEF = out_w(W_DEF, N_DEF, ACC_EN ? ACC_FRAMES_W_DEF : 32'sd0);

endpackage

// File: rtl/dot_product_pipe_if.sv
// Input/output valid-ready bundle of the dot-product pipeline.
// in_last exists only when DOT_ACCUM_EN is defined.
interface dot_product_pipe_if
    import dot_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int N     = N_DEF,
    parameter int OUT_W = OUT_W_DEF
) ();
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   data;
    logic [N*W-1:0]   weight;
`ifdef DOT_ACCUM_EN
    logic             in_last;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out;

    modport master (
        output in_valid, data, weight, out_ready,
`ifdef DOT_ACCUM_EN
        output in_last,
`endif
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, data, weight, out_ready,
`ifdef DOT_ACCUM_EN
        input  in_last,
`endif
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/dot_product_pipe_tree.sv
// One registered adder-tree level: M inputs of IW bits reduce to M/2 sums of IW+1 bits.
module dot_tree_level #(
    parameter int IW = 32,
    parameter int M  = 4
) (
    input  logic                     clk,
    input  logic                     rest,
    input  logic                     i_en,
    input  logic                     i_valid,
    input  logic [M*IW-1:0]          i_data,
    output logic                     o_valid,
    output logic [(M/2)*(IW+1)-1:0]  o_data
);
    localparam int OW = IW + 1;

    logic [(M/2)*OW-1:0] w_sum;
    logic                r_valid;
    logic [(M/2)*OW-1:0] r_data;

    // Pairwise zero-extended sums, so no carry is ever dropped.
    always_comb begin
        w_sum = '0;
        for (int j = 0; j < M / 2; j++) begin
            w_sum[j*OW +: OW] = OW'(i_data[(2*j)*IW +: IW]) + OW'(i_data[(2*j+1)*IW +: IW]);
        end
    end

    // Level register; holds everything, including bubbles, while the pipe is stalled.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_sum;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/dot_product_pipe.sv
// Fully pipelined unsigned dot product with global valid/ready back-pressure.
// DOT_ACCUM_EN adds a frame accumulator after the tree, delimited by in_last.
module dot_product_pipe
    import dot_pkg::*;
#(
    parameter int W            = W_DEF,
    parameter int N            = N_DEF,
    parameter int ACC_FRAMES_W = ACC_FRAMES_W_DEF
) (
    input  logic              clk,
    input  logic              rest,
    dot_product_pipe_if.slave bus
);
    localparam int L      = log2n(N);
    localparam int PW     = lvl_w(W, 0);
    localparam int TREE_W = lvl_w(W, L);
    localparam int OUT_W  = out_w(W, N, ACC_EN ? ACC_FRAMES_W : 0);

    logic              w_adv;
    logic [N*PW-1:0]   w_prod;
    logic [N*PW-1:0]   r_prod;
    logic              r_v0;
    logic [TREE_W-1:0] w_tree;
    logic              w_tree_v;

    assign w_adv        = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = w_adv;

    // Per-lane 2W-bit products.
    always_comb begin
        w_prod = '0;
        for (int i = 0; i < N; i++) begin
            w_prod[i*PW +: PW] = PW'(bus.data[i*W +: W]) * PW'(bus.weight[i*W +: W]);
        end
    end

    // Stage 0: product register; data only loads on an accepted beat.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_v0   <= 1'b0;
            r_prod <= '0;
        end else if (w_adv) begin
            r_v0 <= bus.in_valid;
            if (bus.in_valid) begin
                r_prod <= w_prod;
            end
        end
    end

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int IW = lvl_w(W, k - 1);
        localparam int M  = N >> (k - 1);

        logic [M*IW-1:0]         w_in;
        logic                    w_vin;
        logic [(M/2)*(IW+1)-1:0] w_q;
        logic                    w_vq;

        if (k == 1) begin : g_first
            assign w_in  = r_prod;
            assign w_vin = r_v0;
        end else begin : g_next
            assign w_in  = g_lvl[k-1].w_q;
            assign w_vin = g_lvl[k-1].w_vq;
        end

        dot_tree_level #(.IW(IW), .M(M)) u_lvl (
            .clk     (clk),
            .rest    (rest),
            .i_en    (w_adv),
            .i_valid (w_vin),
            .i_data  (w_in),
            .o_valid (w_vq),
            .o_data  (w_q)
        );
    end

    assign w_tree   = g_lvl[L].w_q;
    assign w_tree_v = g_lvl[L].w_vq;

`ifdef DOT_ACCUM_EN
    logic [L:0]       r_last_pipe;
    logic [OUT_W-1:0] r_acc;
    logic             r_first;
    logic             r_out_valid;

    // in_last tag travels alongside the tree so it lines up with w_tree.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_last_pipe <= '0;
        end else if (w_adv) begin
            r_last_pipe <= {r_last_pipe[L-1:0], bus.in_valid & bus.in_last};
        end
    end

    // Frame accumulator: first beat of a frame reloads, the tagged last beat publishes.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_acc       <= '0;
            r_first     <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_tree_v & r_last_pipe[L];
            if (w_tree_v) begin
                r_acc   <= r_first ? OUT_W'(w_tree) : r_acc + OUT_W'(w_tree);
                r_first <= r_last_pipe[L];
            end
        end
    end

    assign bus.out       = r_acc;
    assign bus.out_valid = r_out_valid;
`else
    assign bus.out       = w_tree;
    assign bus.out_valid = w_tree_v;
`endif

endmodule

// File: tb/tb_dot_product_pipe.sv
// Self-checking bench for dot_product_pipe: vector table, scoreboard, stall/bubble/reset sequences.
module tb_dot_product_pipe;
    import dot_pkg::*;

    localparam int W     = 16;
    localparam int N     = 4;
    localparam int AFW   = 8;
    localparam int OUT_W = out_w(W, N, ACC_EN ? AFW : 0);
    localparam int LAT   = lat_of(N, ACC_EN);

    typedef struct {
        logic [N*W-1:0] d;
        logic [N*W-1:0] w;
        logic [63:0]    exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rest;
    int          total = 0;
    int          bad   = 0;
    logic [63:0] sb[$];
    logic [63:0] drv_exp;
    logic        drv_last;
    vec_t        tbl[7];

    dot_product_pipe_if #(.W(W), .N(N), .OUT_W(OUT_W)) bus ();

    dot_product_pipe #(.W(W), .N(N), .ACC_FRAMES_W(AFW)) dut (
        .clk  (clk),
        .rest (rest),
        .bus  (bus)
    );

`ifdef DOT_ACCUM_EN
    assign bus.in_last = drv_last;
`endif

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [N*W-1:0] pack(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                            input logic [W-1:0] a2, input logic [W-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [63:0] dot(input logic [N*W-1:0] d, input logic [N*W-1:0] w);
        logic [63:0] s = 64'd0;
        for (int i = 0; i < N; i++) begin
            s += 64'(d[i*W +: W]) * 64'(w[i*W +: W]);
        end
        return s;
    endfunction

    // Scoreboard: pop on every output transfer, push when a result-producing beat is accepted.
    always @(negedge clk) begin
        if (rest === 1'b1) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) chk("spurious_out", 64'(bus.out_valid), 64'd0);
                else chk("sb_result", 64'(bus.out), sb.pop_front());
            end
            if (bus.in_valid && bus.in_ready && drv_last) sb.push_back(drv_exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [N*W-1:0] d, input logic [N*W-1:0] w,
                       input logic [63:0] e, input logic last);
        bus.data     = d;
        bus.weight   = w;
        drv_exp      = e;
        drv_last     = last;
        bus.in_valid = 1'b1;
    endtask

    task automatic send(input logic [N*W-1:0] d, input logic [N*W-1:0] w,
                        input logic [63:0] e, input logic last);
        int n = 0;
        put(d, w, e, last);
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk("send_accept", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        repeat (3) tick();
    endtask

    initial begin
        tbl[0] = '{pack(16'd1, 16'd2, 16'd3, 16'd4), pack(16'd5, 16'd6, 16'd7, 16'd8), 64'd70};
        tbl[1] = '{pack(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF),
                   pack(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 64'h3_FFF8_0004};
        tbl[2] = '{pack(16'd0, 16'd0, 16'd0, 16'd0), pack(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 64'd0};
        tbl[3] = '{pack(16'd10, 16'd0, 16'd0, 16'd0), pack(16'd3, 16'd9, 16'd9, 16'd9), 64'd30};
        tbl[4] = '{pack(16'h8000, 16'd1, 16'd2, 16'd3), pack(16'd2, 16'hFFFF, 16'd3, 16'd4), 64'd131089};
        tbl[5] = '{pack(16'd100, 16'd200, 16'd300, 16'd400), pack(16'd1, 16'd1, 16'd1, 16'd1), 64'd1000};
        tbl[6] = '{pack(16'hFFFF, 16'd0, 16'd0, 16'd0), pack(16'hFFFF, 16'd0, 16'd0, 16'd0), 64'hFFFE_0001};

        rest          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data      = '0;
        bus.weight    = '0;
        bus.out_ready = 1'b1;
        drv_exp       = 64'd0;
        drv_last      = 1'b1;

        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out", 64'(bus.out), 64'd0);
        tick();
        tick();
        rest = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Single beat: out_valid in cycle LAT only (beat presented in cycle 0).
        tick();
        put(tbl[0].d, tbl[0].w, tbl[0].exp, 1'b1);
        for (int c = 0; c <= LAT + 2; c++) begin
            @(negedge clk);
            chk($sformatf("basic_valid_c%0d", c), 64'(bus.out_valid), 64'(c == LAT));
            tick();
            bus.in_valid = 1'b0;
        end
        drain();

        for (int i = 0; i < 7; i++) send(tbl[i].d, tbl[i].w, tbl[i].exp, 1'b1);
        drain();

        // Streaming with a 5-cycle output stall once the first result appears.
        fork
            begin
                send(pack(16'd1, 16'd1, 16'd1, 16'd1), pack(16'd1, 16'd1, 16'd1, 16'd1), 64'd4, 1'b1);
                send(pack(16'd2, 16'd2, 16'd2, 16'd2), pack(16'd2, 16'd2, 16'd2, 16'd2), 64'd16, 1'b1);
                send(pack(16'd3, 16'd3, 16'd3, 16'd3), pack(16'd3, 16'd3, 16'd3, 16'd3), 64'd36, 1'b1);
            end
            begin
                int n = 0;
                while (!bus.out_valid && n < 50) begin
                    tick();
                    n++;
                end
                chk("bp_rise", 64'(bus.out_valid), 64'd1);
                bus.out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("bp_hold_out", 64'(bus.out), 64'd4);
                    chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
                    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
                    tick();
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Bubble: in_valid 1,0,1 gives out_valid 1,0,1 starting at cycle LAT.
        put(pack(16'd2, 16'd0, 16'd0, 16'd0), pack(16'd3, 16'd0, 16'd0, 16'd0), 64'd6, 1'b1);
        for (int c = 0; c <= LAT + 3; c++) begin
            @(negedge clk);
            chk($sformatf("bubble_valid_c%0d", c), 64'(bus.out_valid), 64'((c == LAT) || (c == LAT + 2)));
            tick();
            if (c == 1) put(pack(16'd1, 16'd1, 16'd1, 16'd1), pack(16'd9, 16'd9, 16'd9, 16'd9), 64'd36, 1'b1);
            else bus.in_valid = 1'b0;
        end
        drain();

        // Reset with a result at the output and two beats behind it.
        send(pack(16'd7, 16'd7, 16'd7, 16'd7), pack(16'd1, 16'd1, 16'd1, 16'd1), 64'd28, 1'b1);
        send(pack(16'd5, 16'd0, 16'd0, 16'd0), pack(16'd5, 16'd0, 16'd0, 16'd0), 64'd25, 1'b1);
        send(pack(16'd9, 16'd0, 16'd0, 16'd0), pack(16'd9, 16'd0, 16'd0, 16'd0), 64'd81, 1'b1);
        begin
            int n = 0;
            while (!bus.out_valid && n < 20) begin
                tick();
                n++;
            end
        end
        chk("rstmid_pre_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rest = 1'b0;
        #1;
        chk("rstmid_valid", 64'(bus.out_valid), 64'd0);
        chk("rstmid_out", 64'(bus.out), 64'd0);
        sb.delete();
        tick();
        tick();
        rest = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rstmid_quiet", 64'(bus.out_valid), 64'd0);
            tick();
        end
        send(tbl[0].d, tbl[0].w, tbl[0].exp, 1'b1);
        drain();

        // Random gaps and random back-pressure against the reference model.
        fork
            begin
                for (int b = 0; b < 25; b++) begin
                    logic [N*W-1:0] d;
                    logic [N*W-1:0] w;
                    for (int i = 0; i < N; i++) begin
                        d[i*W +: W] = W'($urandom_range(0, 65535));
                        w[i*W +: W] = W'($urandom_range(0, 65535));
                    end
                    send(d, w, dot(d, w), 1'b1);
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
            begin
                repeat (80) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                bus.out_ready = 1'b1;
            end
        join
        bus.out_ready = 1'b1;
        drain();

`ifdef DOT_ACCUM_EN
        send(tbl[0].d, tbl[0].w, 64'd0, 1'b0);
        send(tbl[0].d, tbl[0].w, 64'd0, 1'b0);
        send(tbl[0].d, tbl[0].w, 64'd210, 1'b1);
        send(tbl[0].d, tbl[0].w, 64'd70, 1'b1);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
